// File: rtl/tpu_host_pkg.sv
// rtl/tpu_host_pkg.sv - shared sizes, state encoding and row-counter helpers for tpu_host_seq
package tpu_host_pkg;

    localparam int WORD_SIZE = 256;
    localparam int ROWS      = 32;
    localparam int ROW_IDX_W = 5;
    localparam int ROW_CNT_W = 6;
    localparam int DIM_W     = 5;
    localparam int TIMEOUT   = 1024;
    localparam int WD_W      = 11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FILL  = 3'd1;
    localparam state_t ST_SEND  = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;

    function automatic logic [ROW_CNT_W-1:0] row_inc(input logic [ROW_CNT_W-1:0] cnt);
        return cnt + ROW_CNT_W'(1);
    endfunction

    // Counters run one past the last row index so a full phase is cnt == ROWS.
    function automatic logic row_full(input logic [ROW_CNT_W-1:0] cnt);
        return cnt == ROW_CNT_W'(ROWS);
    endfunction

endpackage

// File: rtl/tpu_host_row_buffer.sv
// rtl/tpu_host_row_buffer.sv - row_buffer: 32x256 storage, synchronous write, combinational read
module row_buffer
    import tpu_host_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE,
    parameter int DEPTH = ROWS,
    parameter int AW    = ROW_IDX_W
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // No reset: every row is rewritten before the sequencer can present it.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tpu_host_seq.sv
// rtl/tpu_host_seq.sv - host sequencer: fill A/B rows, burst to TPU, collect and drain results; TPU_HOST_TIMEOUT_EN adds a WAIT watchdog
module tpu_host_seq
    import tpu_host_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_SIZE-1:0] s_a,
    input  logic [WORD_SIZE-1:0] s_b,
    input  logic [DIM_W-1:0]     s_m,
    input  logic [DIM_W-1:0]     s_n,
    input  logic [DIM_W-1:0]     s_k,
    output logic                 tpu_in_valid,
    output logic [WORD_SIZE-1:0] tpu_a,
    output logic [WORD_SIZE-1:0] tpu_b,
    output logic [DIM_W-1:0]     tpu_m,
    output logic [DIM_W-1:0]     tpu_n,
    output logic [DIM_W-1:0]     tpu_k,
    input  logic                 tpu_out_valid,
    input  logic [WORD_SIZE-1:0] tpu_out,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [WORD_SIZE-1:0] r_data,
    output logic                 r_last,
    output logic                 busy,
    output logic                 err
);

    state_t                 r_state;
    logic [ROW_CNT_W-1:0]   r_row;
    logic                   r_err;
    logic [DIM_W-1:0]       r_m;
    logic [DIM_W-1:0]       r_n;
    logic [DIM_W-1:0]       r_k;

    logic [ROW_CNT_W-1:0]   w_row_nxt;
    logic                   w_row_end;
    logic [ROW_IDX_W-1:0]   w_idx;
    logic                   w_accept;
    logic                   w_capture;
    logic [WORD_SIZE-1:0]   w_a_rd;
    logic [WORD_SIZE-1:0]   w_b_rd;
    logic [WORD_SIZE-1:0]   w_res_rd;

`ifdef TPU_HOST_TIMEOUT_EN
    logic [WD_W-1:0]        r_wd;
    logic [WD_W-1:0]        w_wd_nxt;
    assign w_wd_nxt = r_wd + WD_W'(1);
`endif

    // One counter serves every phase; the phases never overlap.
    assign w_row_nxt = row_inc(r_row);
    assign w_row_end = row_full(w_row_nxt);
    assign w_idx     = r_row[ROW_IDX_W-1:0];
    assign w_accept  = s_valid && s_ready;
    assign w_capture = (r_state == ST_WAIT) && tpu_out_valid;

    row_buffer u_buf_a (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_idx),
        .i_wdata (s_a),
        .i_raddr (w_idx),
        .o_rdata (w_a_rd)
    );

    row_buffer u_buf_b (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (w_idx),
        .i_wdata (s_b),
        .i_raddr (w_idx),
        .o_rdata (w_b_rd)
    );

    row_buffer u_buf_res (
        .clk     (clk),
        .i_we    (w_capture),
        .i_waddr (w_idx),
        .i_wdata (tpu_out),
        .i_raddr (w_idx),
        .o_rdata (w_res_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_err   <= 1'b0;
            r_m     <= '0;
            r_n     <= '0;
            r_k     <= '0;
`ifdef TPU_HOST_TIMEOUT_EN
            r_wd    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_FILL;
                        r_row   <= w_row_nxt;
                        r_err   <= 1'b0;
                        r_m     <= s_m;
                        r_n     <= s_n;
                        r_k     <= s_k;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_row_end) begin
                            r_state <= ST_SEND;
                            r_row   <= '0;
                        end else begin
                            r_row   <= w_row_nxt;
                        end
                    end
                end
                // The accelerator needs all 32 rows on consecutive cycles.
                ST_SEND: begin
                    if (w_row_end) begin
                        r_state <= ST_WAIT;
                        r_row   <= '0;
`ifdef TPU_HOST_TIMEOUT_EN
                        r_wd    <= '0;
`endif
                    end else begin
                        r_row   <= w_row_nxt;
                    end
                end
                ST_WAIT: begin
                    if (tpu_out_valid) begin
`ifdef TPU_HOST_TIMEOUT_EN
                        r_wd    <= '0;
`endif
                        if (w_row_end) begin
                            r_state <= ST_DRAIN;
                            r_row   <= '0;
                        end else begin
                            r_row   <= w_row_nxt;
                        end
                    end
`ifdef TPU_HOST_TIMEOUT_EN
                    else if (w_wd_nxt == WD_W'(TIMEOUT)) begin
                        r_state <= ST_IDLE;
                        r_row   <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wd    <= w_wd_nxt;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (r_ready) begin
                        if (w_row_end) begin
                            r_state <= ST_IDLE;
                            r_row   <= '0;
                        end else begin
                            r_row   <= w_row_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_row   <= '0;
                end
            endcase

            // A stray result beat wins over the clear on a new fill.
            if (tpu_out_valid && (r_state != ST_WAIT)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_ready      = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign tpu_in_valid = (r_state == ST_SEND);
    assign tpu_a        = tpu_in_valid ? w_a_rd : '0;
    assign tpu_b        = tpu_in_valid ? w_b_rd : '0;
    assign tpu_m        = r_m;
    assign tpu_n        = r_n;
    assign tpu_k        = r_k;
    assign r_valid      = (r_state == ST_DRAIN);
    assign r_data       = r_valid ? w_res_rd : '0;
    assign r_last       = r_valid && (w_idx == ROW_IDX_W'(ROWS - 1));
    assign busy         = (r_state != ST_IDLE);
    assign err          = r_err;

endmodule

// File: doc/tpu_host_seq.md
TPU_HOST_SEQ -- requirements
Module: tpu_host_seq

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, the single clock.
REQ-002 SHALL have port `rst_n`: input, 1 bit, reset that is synchronous and active-low.
REQ-003 SHALL have ports `s_valid` (input, 1), `s_ready` (output, 1), `s_a` (input, 256) and `s_b` (input, 256): the upstream A/B row stream.
REQ-004 SHALL have ports `s_m`, `s_n`, `s_k`: input, 5 each, matrix dimensions sampled on the first accepted beat.
REQ-005 SHALL have ports `tpu_in_valid` (output, 1), `tpu_a` (output, 256), `tpu_b` (output, 256): the burst to the accelerator top.
REQ-006 SHALL have ports `tpu_m`, `tpu_n`, `tpu_k`: output, 5 each, the registered dimensions.
REQ-007 SHALL have ports `tpu_out_valid` (input, 1) and `tpu_out` (input, 256): the result beats from the accelerator top.
REQ-008 SHALL have ports `r_valid` (output, 1), `r_ready` (input, 1), `r_data` (output, 256), `r_last` (output, 1): the downstream result stream.
REQ-009 SHALL have ports `busy` (output, 1, high when not IDLE) and `err` (output, 1, sticky protocol/timeout error).

Function
REQ-010 SHALL implement states IDLE, FILL, SEND, WAIT, DRAIN.
REQ-011 SHALL drive `s_ready`=1 only in IDLE and FILL; a beat is accepted when `s_valid`&&`s_ready`.
REQ-012 SHALL move IDLE->FILL on the first accepted beat, store it as row 0, and clear `err`.
REQ-013 SHALL store accepted rows 0..31 in order into the A and B buffers; upstream stalls are allowed.
REQ-014 SHALL enter SEND on the cycle after row 31 is accepted.
REQ-015 SHALL, in SEND, hold `tpu_in_valid`=1 for exactly 32 consecutive cycles, presenting rows 0..31 with no gaps; the accelerator cannot tolerate gaps.
REQ-016 SHALL drive `tpu_a`/`tpu_b`=0 whenever `tpu_in_valid`=0.
REQ-017 SHALL enter WAIT after the 32nd SEND cycle.
REQ-018 SHALL, in WAIT, capture every `tpu_out_valid` beat into the result buffer rows 0..31; beats need not be contiguous.
REQ-019 SHALL enter DRAIN on the cycle after the 32nd captured beat; any further beats in that same WAIT phase are ignored.
REQ-020 SHALL flag `err`=1 for any `tpu_out_valid` beat outside WAIT; such a beat is otherwise ignored.
REQ-021 SHALL, in DRAIN, present result rows 0..31 in order with `r_valid`=1.
REQ-022 SHALL hold `r_data` stable while `r_valid`&&!`r_ready` and advance only on a handshake.
REQ-023 SHALL assert `r_last`=1 only with row 31; `r_data`=0 when `r_valid`=0.
REQ-024 SHALL return to IDLE on the cycle after the row-31 handshake; a new FILL may start on that IDLE cycle.
REQ-025 SHALL implement row counters as 6-bit values, compare for terminal value 32, and never wrap silently.

Reset
REQ-026 SHALL, while `rst_n`=0 at a clock edge, set state to IDLE, all counters to 0, and `s_ready`=1 (IDLE).
REQ-027 SHALL, while `rst_n`=0 at a clock edge, drive `tpu_in_valid`, `r_valid`, `r_last`, `busy`, `err` and all data outputs to 0, and `tpu_m`/`tpu_n`/`tpu_k`=0.
REQ-028 SHALL abort any phase when reset is asserted mid-operation; buffer contents are don't-care and are never presented before being rewritten.

Configuration
REQ-029 SHALL, with `TPU_HOST_TIMEOUT_EN` defined, run an 11-bit watchdog in WAIT that resets on each captured beat; on reaching 1024 idle cycles it sets `err`=1 and moves to IDLE.
REQ-030 SHALL, without `TPU_HOST_TIMEOUT_EN`, have WAIT never time out and instantiate no watchdog logic.

Structure
REQ-031 SHALL take from shared package `tpu_host_pkg`: WORD_SIZE=256, ROWS=32, ROW_IDX_W=5, TIMEOUT=1024, and the state typedef.
REQ-032 SHALL use sub-module `row_buffer` (32x256, one synchronous write port, one combinational read port), instanced for A, B and results.

Verification
REQ-033 SHALL check: 32 back-to-back beats A[i]=i, B[i]=~i, m=n=k=31 -> SEND shows 32 contiguous `tpu_in_valid` cycles with `tpu_a`=0..31 and `tpu_m`=31.
REQ-034 SHALL check: upstream `s_valid` toggled randomly during FILL -> SEND output is still gap-free and in order.
REQ-035 SHALL check: 32 result beats with a 5-cycle gap after beat 10, `r_ready` held low 3 cycles at row 7 -> `r_data` stable during the stall and `r_last` only on row 31.
REQ-036 SHALL check: `tpu_out_valid` pulsed during FILL -> `err`=1, FILL unaffected, `err` cleared at the next FILL start.
REQ-037 SHALL check: `rst_n` low for 1 cycle mid-SEND at row 12 -> `tpu_in_valid`=0 the next cycle and IDLE; a fresh 32-row load completes correctly.
REQ-038 SHALL check, with `TPU_HOST_TIMEOUT_EN`: only 20 result beats -> `err`=1 and IDLE exactly 1024 cycles after beat 20.
